instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction prefetch queue between instruction memory and the processor core.
//  Fetches sequential words ahead of the core into a DEPTH-entry {pc,instr} queue.
//  Presents the instruction matching the core's PC with a valid flag; the core stalls while invalid.
//  A PC mismatch (taken branch/jal/jalr) flushes the queue and restarts fetch at the new PC.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, 2..16; also the cap on queued+outstanding fetches
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  cpu_pc       in   32  PC the core wants now; bits [1:0] ignored
//  cpu_advance  in   1   core consumes cpu_instr this cycle; only meaningful when cpu_valid=1
//  cpu_instr    out  32  instruction for cpu_pc; NOP (32'h0000_0013) when cpu_valid=0
//  cpu_valid    out  1   queue head pc == cpu_pc
//  mem_req      out  1   fetch request
//  mem_addr     out  32  fetch address (fetch_pc), bits [1:0] always 0
//  mem_gnt      in   1   request accepted this cycle; only meaningful with mem_req
//  mem_rvalid   in   1   read data returns, in request order, >=1 cycle after grant
//  mem_rdata    in   32  returned instruction word
// BEHAVIOUR
//  Reset (reset=0, async):
//   - queue empty; fetch_pc=0; outstanding=0; drop_cnt=0.
//   - Outputs: cpu_valid=0, cpu_instr=NOP, mem_req=0, mem_addr=0.
//   - The memory side shares this reset; no pre-reset response arrives afterwards.
//  Issue:
//   - mem_req=1 when occupancy+outstanding < DEPTH and no redirect this cycle.
//   - On mem_gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0); outstanding++.
//  Return:
//   - On mem_rvalid: outstanding--.
//   - If drop_cnt>0: drop_cnt--, data discarded. Else push {pc_of_response, mem_rdata}.
//   - pc_of_response = separate tag counter, advanced per non-dropped return.
//  Consume:
//   - cpu_valid = !empty && head.pc[31:2]==cpu_pc[31:2] (combinational).
//   - Pop on cpu_valid && cpu_advance.
//  Redirect:
//   - When cpu_valid=0 and cpu_pc is neither head.pc nor (empty && next expected pc):
//     next cycle queue empty, fetch_pc = tag = {cpu_pc[31:2],2'b00}.
//   - drop_cnt = outstanding after this cycle's grant/return are counted.
//   - A grant in the redirect cycle is counted into drop_cnt; mem_req is 0 that cycle.
//  Simultaneous events:
//   - Push+pop in one cycle: occupancy unchanged. Full queue + push is impossible by issue rule.
//   - Redirect and rvalid in the same cycle: the rvalid word is dropped.
//  Latency: redirect to first cpu_valid = 1 (redirect) + 1 (issue) + memory latency + 1 (queue write).
//  FSM: RUN / FLUSH. FLUSH is held while drop_cnt>0; issue for the new stream is allowed in FLUSH.
// CONFIGURATION
//  PF_BYPASS_EN defined:
//   - If the queue is empty, drop_cnt=0 and the returning word's pc matches cpu_pc,
//     mem_rdata goes straight to cpu_instr with cpu_valid=1 in the same cycle.
//   - If cpu_advance is also 1 that cycle, the word is not pushed; otherwise it is pushed as usual.
//  PF_BYPASS_EN undefined: every word passes through the queue (>=1 cycle return-to-valid).
// STRUCTURE
//  Shared package/header:
//   - INSTR_W=32, NOP_INSTR=32'h0000_0013, PC_STEP=4.
//   - State encoding: PF_RUN=1'b0, PF_FLUSH=1'b1.
//  Sub-module: pf_queue. Sync FIFO of {pc,instr}, DEPTH entries, push/pop/flush.
//   - Exposes head, empty, full, count. Pointers wrap modulo DEPTH.
//  Top level: issue/tag counters, outstanding/drop counters, FSM, bypass.
// TESTING
//  1 Reset, cpu_pc=0, 1-cycle memory, cpu_advance=1 always
//    -> addrs 0,4,8 issued; cpu_valid high from cycle 3 with 3 words in order.
//  2 cpu_advance=0 with DEPTH=4 -> exactly 4 grants then mem_req=0;
//    queue holds pcs 0,4,8,C; no overflow.
//  3 Stream at pc 8, core sets cpu_pc=0x40 with 2 outstanding
//    -> 2 returns dropped; next valid instr has pc 0x40; no stale word shown.
//  4 fetch_pc=32'hFFFF_FFF8 -> issues FFF8, FFFC, then 0000_0000.
//  5 reset=0 asserted mid-stream with 3 queued
//    -> cpu_valid=0, mem_req=0 immediately (async); fetch restarts at 0 after release.
//  6 PF_BYPASS_EN, empty queue, rvalid for cpu_pc
//    -> cpu_valid=1, same-cycle cpu_instr=mem_rdata; undefined: one cycle later.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional same-cycle return bypass is enabled by defining PF_BYPASS_EN.
package instr_prefetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        PF_RUN   = 1'b0,
        PF_FLUSH = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } pf_entry_t;

    // Word-aligns a byte address; the low two bits never select anything.
    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_prefetch_pf_queue.sv
// Synchronous FIFO of {pc,instr} entries with push, pop and a flush that empties it.
// Pointers wrap modulo DEPTH (DEPTH is a power of two).
module pf_queue
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pf_entry_t              push_data,
    input  logic                   pop,
    input  logic                   flush,
    output pf_entry_t              head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pf_entry_t       entries [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= push_data;
    end

    assign head  = entries[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches sequential words ahead of the core and flushes on a PC change.
// Define PF_BYPASS_EN to forward a returning word straight to the core when the queue is empty.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_advance,
    output logic [31:0] cpu_instr,
    output logic        cpu_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] fetch_pc;
    logic [31:0] tag_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    pf_state_e   state;

    pf_entry_t   q_head;
    pf_entry_t   q_push_data;
    logic        q_empty;
    logic        q_full;
    logic        q_push;
    logic        q_pop;
    logic [CW-1:0] q_count;

    logic        head_hit;
    logic        tag_hit;
    logic        bypass_hit;
    logic        redirect;
    logic        grant;
    logic        accept;
    logic [CW-1:0] outstanding_nxt;
    logic [CW:0] occupancy;

    assign head_hit = !q_empty && (pc_align(q_head.pc) == pc_align(cpu_pc));
    assign tag_hit  = (pc_align(tag_pc) == pc_align(cpu_pc));

`ifdef PF_BYPASS_EN
    assign bypass_hit = reset && q_empty && (drop_cnt == '0) && mem_rvalid && tag_hit;
`else
    assign bypass_hit = 1'b0;
`endif

    assign cpu_valid = head_hit || bypass_hit;

    always_comb begin
        cpu_instr = NOP_INSTR;
        if (head_hit)        cpu_instr = q_head.instr;
        else if (bypass_hit) cpu_instr = mem_rdata;
    end

    // An empty queue whose next expected word is cpu_pc is merely waiting, not mispredicted.
    assign redirect = !cpu_valid && !(q_empty && tag_hit);

    assign occupancy = {1'b0, q_count} + {1'b0, outstanding};
    assign mem_req   = reset && !redirect && !q_full && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr  = fetch_pc;
    assign grant     = mem_req && mem_gnt;

    assign accept      = mem_rvalid && (drop_cnt == '0) && !redirect;
    assign q_push      = accept && !(bypass_hit && cpu_advance);
    assign q_pop       = head_hit && cpu_advance;
    assign q_push_data = '{pc: tag_pc, instr: mem_rdata};

    assign outstanding_nxt = outstanding + CW'(grant) - CW'(mem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= '0;
            tag_pc      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= PF_RUN;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                // Everything still in flight belongs to the old stream and must be discarded.
                fetch_pc <= pc_align(cpu_pc);
                tag_pc   <= pc_align(cpu_pc);
                drop_cnt <= outstanding_nxt;
                state    <= (outstanding_nxt != '0) ? PF_FLUSH : PF_RUN;
            end else begin
                if (grant)  fetch_pc <= fetch_pc + PC_STEP;
                if (accept) tag_pc   <= tag_pc + PC_STEP;
                case (state)
                    PF_FLUSH: begin
                        if (mem_rvalid) drop_cnt <= drop_cnt - CW'(1);
                        if (drop_cnt == '0 || (drop_cnt == CW'(1) && mem_rvalid))
                            state <= PF_RUN;
                    end
                    default: state <= PF_RUN;
                endcase
            end
        end
    end

    pf_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: in-order memory model, core driver, scoreboard monitor.
// Expected words come from a fixed address->data function; fetch addresses from stream order.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef PF_BYPASS_EN
    localparam int FILL_LAT = 1;
`else
    localparam int FILL_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_pc = '0;
    logic        cpu_advance = 1'b0;
    logic [31:0] cpu_instr;
    logic        cpu_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    instr_prefetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_pc      (cpu_pc),
        .cpu_advance (cpu_advance),
        .cpu_instr   (cpu_instr),
        .cpu_valid   (cpu_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared bench state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_fetch = '0;
    int          gnt_cnt = 0;
    int          first_gnt = -1;
    int          first_val = -1;
    bit          redirect_now = 1'b0;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100, adv_pct = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] al;
        al = a & 32'hFFFF_FFFC;
        return (al * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory model: in-order, latency lat_min..lat_max ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                pend_addr.delete();
                pend_due.delete();
                mem_rvalid = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            mem_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_fetch = '0;
            gnt_cnt   = 0;
            first_gnt = -1;
            first_val = -1;
        end else begin
            if (cpu_valid) begin
                check("instr_for_pc", cpu_instr, mem_word(cpu_pc));
                if (first_val < 0) first_val = cyc;
            end else begin
                check("nop_when_invalid", cpu_instr, NOP_INSTR);
            end
            if (redirect_now) begin
                check("req_low_on_redirect", {31'b0, mem_req}, 32'h0);
                exp_fetch = cpu_pc & 32'hFFFF_FFFC;
            end else if (mem_req && mem_gnt) begin
                check("fetch_addr", mem_addr, exp_fetch);
                check("in_flight_cap", {31'b0, pend_addr.size() < DEPTH}, 32'h1);
                exp_fetch = exp_fetch + 32'd4;
                pend_addr.push_back(mem_addr);
                pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                gnt_cnt++;
                if (first_gnt < 0) first_gnt = cyc;
            end
            if (cpu_valid && cpu_advance) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_consume", cpu_pc, 32'hDEAD_BEEF);
                end else begin
                    check("consumed_instr", cpu_instr, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    task automatic do_reset();
        reset        = 1'b0;
        cpu_pc       = '0;
        cpu_advance  = 1'b0;
        redirect_now = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_cpu_valid", {31'b0, cpu_valid}, 32'h0);
        check("rst_cpu_instr", cpu_instr, NOP_INSTR);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Present one PC and hold it until the core consumes it.
    task automatic consume(input logic [31:0] pc, input bit branch);
        bit fired;
        cpu_pc       = pc;
        redirect_now = branch;
        exp_q.push_back(mem_word(pc));
        for (int t = 0; t < 200; t++) begin
            cpu_advance = ($urandom_range(0, 99) < adv_pct);
            @(negedge clk);
            fired = cpu_valid && cpu_advance;
            @(posedge clk);
            #1;
            redirect_now = 1'b0;
            if (fired) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL consume_timeout: pc %h never delivered, expected within 200 cycles", pc);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] cur;
        logic [31:0] tgt;

        // Sequential fetch from reset, 1-cycle memory, core always advancing.
        lat_min = 1; lat_max = 1; gnt_pct = 100; adv_pct = 100;
        do_reset();
        consume(32'h0, 1'b0);
        consume(32'h4, 1'b0);
        consume(32'h8, 1'b0);
        check("fill_latency", 32'(first_val - first_gnt), 32'(FILL_LAT));

        // Stalled core: exactly DEPTH fetches, then the request drops.
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        check("grants_when_stalled", 32'(gnt_cnt), 32'(DEPTH));
        @(negedge clk);
        check("req_low_when_full", {31'b0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) consume(32'(i * 4), 1'b0);

        // Taken branch with fetches in flight: stale returns must be discarded.
        lat_min = 3; lat_max = 3;
        do_reset();
        consume(32'h0, 1'b0);
        consume(32'h4, 1'b0);
        consume(32'h8, 1'b0);
        consume(32'h41, 1'b1);
        consume(32'h44, 1'b0);
        consume(32'h48, 1'b0);

        // Fetch address wraps past the top of memory.
        lat_min = 2; lat_max = 2;
        do_reset();
        consume(32'h0, 1'b0);
        consume(32'hFFFF_FFF8, 1'b1);
        consume(32'hFFFF_FFFC, 1'b0);
        consume(32'h0, 1'b0);
        consume(32'h4, 1'b0);

        // Asynchronous reset mid-stream with the queue holding words.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (8) @(posedge clk);
        #3;
        check("pre_reset_valid", {31'b0, cpu_valid}, 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, cpu_valid}, 32'h0);
        check("async_rst_req", {31'b0, mem_req}, 32'h0);
        check("async_rst_instr", cpu_instr, NOP_INSTR);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        consume(32'h0, 1'b0);
        consume(32'h4, 1'b0);
        consume(32'h8, 1'b0);

        // Randomized program flow under varying memory behaviour.
        for (int r = 0; r < 3; r++) begin
            lat_min = 1;
            lat_max = 1 + 2 * r;
            gnt_pct = 100 - 25 * r;
            adv_pct = 90 - 20 * r;
            do_reset();
            consume(32'h0, 1'b0);
            cur = 32'h0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) < 15) begin
                    if ($urandom_range(0, 9) == 0)
                        tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
                    else
                        tgt = 32'($urandom_range(0, 1023)) << 2;
                end else begin
                    tgt = cur + 32'd4;
                end
                consume(tgt | 32'($urandom_range(0, 3)), tgt != cur + 32'd4);
                cur = tgt;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
